// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM states and the baud divisor.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

    // Clock cycles per bit, truncated; shared with the receiver side.
    function automatic int baud_tick(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_TICK-1 and flags the last cycle of a bit.
module uart_baud_gen #(
    parameter int BAUD_TICK = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] TICK_MAX = 16'(BAUD_TICK - 1);

    logic [15:0] cnt;

    assign tick = (cnt == TICK_MAX);

    // Wrap at the end of every bit; held at zero while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (clear || tick) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, LSB-first serial frame on tx.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int BAUD_TICK  = baud_tick(CLOCK_FREQ, BAUD_RATE),
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic       HAS_PARITY    = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);
    localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

    uart_state_t state;
    uart_state_t state_nxt;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [2:0]  bit_idx;
    logic        tick;
    logic        last_stop;
    logic        accept;
    logic        line_nxt;

    // Parity over the whole byte, computed once at accept since shifting destroys it.
    function automatic logic parity_bit(input logic [7:0] data);
        return (^data) ^ (PARITY == PARITY_ODD);
    endfunction

    uart_baud_gen #(
        .BAUD_TICK(BAUD_TICK)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state == S_IDLE),
        .tick (tick)
    );

    // The final stop-bit cycle counts as idle so a new byte can follow with no gap.
    assign last_stop = (state == S_STOP) && (bit_idx == LAST_STOP_IDX) && tick;
    assign tx_ready  = (state == S_IDLE) || last_stop;
    assign tx_busy   = (state != S_IDLE) && !last_stop;
    assign tx_done   = last_stop;
    assign accept    = tx_valid && tx_ready;

    // Next state and line level of the current state.
    always_comb begin
        state_nxt = state;
        line_nxt  = 1'b1;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_START;
            end
            S_START: begin
                line_nxt = 1'b0;
                if (tick) state_nxt = S_DATA;
            end
            S_DATA: begin
                line_nxt = shift_q[0];
                if (tick && (bit_idx == 3'd7)) state_nxt = HAS_PARITY ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                line_nxt = par_q;
                if (tick) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (last_stop) state_nxt = accept ? S_START : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Bit index within DATA and STOP; restarts whenever the state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 3'd0;
        end else if (state_nxt != state) begin
            bit_idx <= 3'd0;
        end else if (tick && ((state == S_DATA) || (state == S_STOP))) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Byte and parity capture on accept, right shift at each data-bit boundary.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_q <= tx_data;
            par_q   <= parity_bit(tx_data);
        end else if ((state == S_DATA) && tick) begin
            shift_q <= {1'b0, shift_q[7:1]};
        end
    end

    // Registered serial line, forced high by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx <= 1'b1;
        else        tx <= line_nxt;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances covering 8N1, odd, even and 2 stop bits.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CF = 1600;
    localparam int BR = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v    [4];
    logic [7:0] d    [4];
    logic       line [4];
    logic       rdy  [4];
    logic       busy [4];
    logic       done [4];

    logic tx_log   [0:400];
    logic rdy_log  [0:400];
    logic done_log [0:400];

    logic [7:0] sb [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(d[0]), .tx_valid(v[0]),
        .tx_ready(rdy[0]), .tx(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .PARITY(PARITY_ODD)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d[1]), .tx_valid(v[1]),
        .tx_ready(rdy[1]), .tx(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .PARITY(PARITY_EVEN)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(d[2]), .tx_valid(v[2]),
        .tx_ready(rdy[2]), .tx(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data(d[3]), .tx_valid(v[3]),
        .tx_ready(rdy[3]), .tx(line[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    // Count of logged samples that disagree with the ideal frame starting after accept at base.
    function automatic int frame_errors(input int base, input logic [7:0] val,
                                        input int par, input int stops);
        logic exp_bits [0:11];
        int nb;
        int errs;
        nb = 10 + ((par != 0) ? 1 : 0) + (stops - 1);
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i + 1] = val[i];
        if (par != 0) exp_bits[9] = (^val) ^ (par == PARITY_ODD);
        for (int j = 9 + ((par != 0) ? 1 : 0); j < nb; j++) exp_bits[j] = 1'b1;
        errs = 0;
        for (int j = 0; j < nb; j++)
            for (int s = 0; s < 16; s++)
                if (tx_log[base + 2 + 16 * j + s] !== exp_bits[j]) errs++;
        return errs;
    endfunction

    // Receiver model: sample each data bit at its middle.
    function automatic logic [7:0] decode(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = tx_log[base + 10 + 16 * (i + 1)];
        return b;
    endfunction

    task automatic accept_byte(input int idx, input logic [7:0] val);
        @(negedge clk);
        v[idx] = 1'b1;
        d[idx] = val;
        n_cmp++;
        if (rdy[idx] !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_ready[%0d]: tx_ready=%b required 1", idx, rdy[idx]);
        end
        sb.push_back(val);
        @(posedge clk);
        #1;
    endtask

    // Log n cycles after an accept; optional valid drop and a mid-frame valid pulse.
    task automatic record(input int idx, input int n, input int drop_k,
                          input int p_from, input int p_to, input logic [7:0] p_data);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tx_log[k]   = line[idx];
            rdy_log[k]  = rdy[idx];
            done_log[k] = done[idx];
            if (k == drop_k) v[idx] = 1'b0;
            if (k == p_from) begin
                v[idx] = 1'b1;
                d[idx] = p_data;
            end
            if (k == p_to) v[idx] = 1'b0;
        end
    endtask

    task automatic sb_check(input string name, input int base);
        logic [7:0] exp_b;
        logic [7:0] got;
        got = decode(base);
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: decoded 0x%02h with empty scoreboard", name, got);
        end else begin
            exp_b = sb.pop_front();
            if (got !== exp_b) begin
                n_bad++;
                $display("FAIL %s: decoded 0x%02h required 0x%02h", name, got, exp_b);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({line[i], rdy[i], busy[i], done[i]} !== 4'b1100) begin
                n_bad++;
                $display("FAIL reset[%0d]: tx/ready/busy/done=%b%b%b%b required 1100",
                         i, line[i], rdy[i], busy[i], done[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_8n1();
        int errs;
        int nd;
        int dpos;
        int rdy_low;
        accept_byte(0, 8'hA5);
        v[0] = 1'b0;
        record(0, 180, 0, 0, 0, 8'h00);
        n_cmp++;
        if (tx_log[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL 8n1_latency: tx=%b in accept cycle required 1", tx_log[1]);
        end
        errs = frame_errors(0, 8'hA5, 0, 1);
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL 8n1_frame: %0d bad samples required 0", errs);
        end
        nd = 0; dpos = -1; rdy_low = 0;
        for (int k = 1; k <= 180; k++) begin
            if (done_log[k] === 1'b1) begin nd++; dpos = k; end
            if ((k <= 159) && (rdy_log[k] === 1'b0)) rdy_low++;
        end
        n_cmp++;
        if ((nd !== 1) || (dpos !== 160)) begin
            n_bad++;
            $display("FAIL 8n1_done: %0d pulses last at %0d required 1 at 160", nd, dpos);
        end
        n_cmp++;
        if ((rdy_low !== 159) || (rdy_log[160] !== 1'b1)) begin
            n_bad++;
            $display("FAIL 8n1_ready: low %0d cycles ready@160=%b required 159 and 1",
                     rdy_low, rdy_log[160]);
        end
        sb_check("8n1_data", 0);
    endtask

    task automatic test_parity();
        int idx_t [3] = '{2, 1, 1};
        int par_t [3] = '{PARITY_EVEN, PARITY_ODD, PARITY_ODD};
        logic [7:0] val_t [3] = '{8'hA5, 8'hA5, 8'h01};
        logic pbit_t [3] = '{1'b0, 1'b1, 1'b0};
        int errs;
        int nd;
        int dpos;
        for (int t = 0; t < 3; t++) begin
            accept_byte(idx_t[t], val_t[t]);
            v[idx_t[t]] = 1'b0;
            record(idx_t[t], 190, 0, 0, 0, 8'h00);
            n_cmp++;
            if (tx_log[154] !== pbit_t[t]) begin
                n_bad++;
                $display("FAIL parity_bit[%0d]: %b required %b", t, tx_log[154], pbit_t[t]);
            end
            errs = frame_errors(0, val_t[t], par_t[t], 1);
            n_cmp++;
            if (errs !== 0) begin
                n_bad++;
                $display("FAIL parity_frame[%0d]: %0d bad samples required 0", t, errs);
            end
            nd = 0; dpos = -1;
            for (int k = 1; k <= 190; k++)
                if (done_log[k] === 1'b1) begin nd++; dpos = k; end
            n_cmp++;
            if ((nd !== 1) || (dpos !== 176)) begin
                n_bad++;
                $display("FAIL parity_done[%0d]: %0d pulses last at %0d required 1 at 176", t, nd, dpos);
            end
            sb_check("parity_data", 0);
        end
    endtask

    task automatic test_two_stop();
        int errs;
        int nd;
        int dpos;
        accept_byte(3, 8'h00);
        v[3] = 1'b0;
        record(3, 190, 0, 0, 0, 8'h00);
        errs = frame_errors(0, 8'h00, 0, 2);
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL stop2_frame: %0d bad samples required 0", errs);
        end
        nd = 0; dpos = -1;
        for (int k = 1; k <= 190; k++)
            if (done_log[k] === 1'b1) begin nd++; dpos = k; end
        n_cmp++;
        if ((nd !== 1) || (dpos !== 176)) begin
            n_bad++;
            $display("FAIL stop2_done: %0d pulses last at %0d required 1 at 176", nd, dpos);
        end
        sb_check("stop2_data", 0);
    endtask

    task automatic test_back_to_back();
        int errs;
        int nd;
        int pos [2];
        accept_byte(0, 8'h55);
        d[0] = 8'h0F;
        sb.push_back(8'h0F);
        record(0, 340, 161, 0, 0, 8'h00);
        errs = frame_errors(0, 8'h55, 0, 1) + frame_errors(160, 8'h0F, 0, 1);
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL b2b_frames: %0d bad samples required 0", errs);
        end
        nd = 0; pos[0] = -1; pos[1] = -1;
        for (int k = 1; k <= 340; k++)
            if (done_log[k] === 1'b1) begin
                if (nd < 2) pos[nd] = k;
                nd++;
            end
        n_cmp++;
        if ((nd !== 2) || (pos[0] !== 160) || (pos[1] !== 320)) begin
            n_bad++;
            $display("FAIL b2b_done: %0d pulses at %0d,%0d required 2 at 160,320", nd, pos[0], pos[1]);
        end
        sb_check("b2b_first", 0);
        sb_check("b2b_second", 160);
    endtask

    task automatic test_busy_ignore();
        int errs;
        int nd;
        int lows;
        accept_byte(0, 8'h3C);
        v[0] = 1'b0;
        record(0, 340, 0, 50, 60, 8'hFF);
        errs = frame_errors(0, 8'h3C, 0, 1);
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL busy_frame: %0d bad samples required 0", errs);
        end
        nd = 0; lows = 0;
        for (int k = 1; k <= 340; k++) begin
            if (done_log[k] === 1'b1) nd++;
            if ((k >= 162) && (tx_log[k] !== 1'b1)) lows++;
        end
        n_cmp++;
        if ((nd !== 1) || (lows !== 0)) begin
            n_bad++;
            $display("FAIL busy_extra: %0d done pulses, %0d non-idle samples required 1 and 0", nd, lows);
        end
        sb_check("busy_data", 0);
    endtask

    task automatic test_reset_mid_frame();
        int errs;
        int nd;
        accept_byte(0, 8'hC3);
        v[0] = 1'b0;
        repeat (69) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (line[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_pre: tx=%b during data bit 3 required 0", line[0]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({line[0], rdy[0], busy[0]} !== 3'b110) begin
            n_bad++;
            $display("FAIL rst_async: tx/ready/busy=%b%b%b required 110", line[0], rdy[0], busy[0]);
        end
        sb.delete();
        nd = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if ((done[0] !== 1'b0) || (line[0] !== 1'b1)) nd++;
        end
        n_cmp++;
        if (nd !== 0) begin
            n_bad++;
            $display("FAIL rst_hold: %0d bad cycles in reset required 0", nd);
        end
        rst_n = 1'b1;
        v[0] = 1'b1;
        d[0] = 8'h81;
        sb.push_back(8'h81);
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        record(0, 180, 0, 0, 0, 8'h00);
        errs = frame_errors(0, 8'h81, 0, 1);
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL rst_resend_frame: %0d bad samples required 0", errs);
        end
        nd = 0;
        for (int k = 1; k <= 180; k++) if (done_log[k] === 1'b1) nd++;
        n_cmp++;
        if ((nd !== 1) || (done_log[160] !== 1'b1)) begin
            n_bad++;
            $display("FAIL rst_resend_done: %0d pulses done@160=%b required 1 and 1", nd, done_log[160]);
        end
        sb_check("rst_resend_data", 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            v[i] = 1'b0;
            d[i] = 8'h00;
        end
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
